// File: rtl/fsm_stim_sequencer.sv
// fsm_stim_sequencer: paced stimulus and hit counting for the seq4 sequence-detector FSM
module fsm_stim_sequencer #(
   parameter int PAT_LEN = 16,
   parameter int IDX_W   = 4,
   parameter int DIV_W   = 26
) (
   input  logic               Clock,
   input  logic               nReset,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               step_i,
   input  logic [PAT_LEN-1:0] pattern_i,
   input  logic [DIV_W-1:0]   period_i,
   input  logic               z_i,
   output logic               step_o,
   output logic               w_o,
   output logic               fsm_nreset_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic [7:0]         hits_o
);
   localparam int CW = IDX_W + 1;
   localparam logic [CW-1:0] LAST = CW'(PAT_LEN);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CLEAR = 3'd1;
   localparam logic [2:0] RUN   = 3'd2;
   localparam logic [2:0] PAUSE = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;
   logic [2:0]         state_q, state_d;
   logic [DIV_W-1:0]   tick_q, tick_d, per_m1;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [PAT_LEN-1:0] sh_q, sh_d;
   logic [7:0]         hits_q, hits_d;
   logic               step_q, step_d, pstep_q, pstep_d, zs_q, zs_d, w_q, w_d;
   logic               fnr_q, fnr_d, busy_q, busy_d, done_q, done_d;
   logic               fire, clear, fin, tick_end;
   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      w_d      = w_q;
      hits_d   = (zs_q && z_i && hits_q != 8'hFF) ? hits_q + 8'd1 : hits_q;
      fire     = 1'b0;
      clear    = 1'b0;
      per_m1   = period_i - DIV_W'(period_i != '0);
      tick_end = tick_q >= per_m1;
      // fin waits until the last step's z sample is being taken this cycle
      fin      = (cnt_q == LAST) && !pstep_q;
      case (state_q)
         IDLE: clear = start_i && !stop_i;
         CLEAR, RUN: begin
            state_d = stop_i ? PAUSE : fin ? DONE : RUN;
            tick_d  = (stop_i || tick_end) ? '0 : tick_q + 1'b1;
            fire    = !stop_i && tick_end && cnt_q != LAST;
         end
         PAUSE: begin
            state_d = stop_i ? IDLE : fin ? DONE : start_i ? RUN : PAUSE;
            fire    = !stop_i && !start_i && step_i && !step_q && cnt_q != LAST;
         end
         DONE: begin
            state_d = stop_i ? IDLE : DONE;
            clear   = start_i && !stop_i;
         end
         default: state_d = IDLE;
      endcase
      if (clear) begin
         state_d = CLEAR;
         sh_d    = pattern_i;
         cnt_d   = '0;
         hits_d  = '0;
         tick_d  = '0;
         w_d     = 1'b0;
      end
      if (fire) begin
         w_d   = sh_q[0];
         sh_d  = sh_q >> 1;
         cnt_d = cnt_q + 1'b1;
      end
      step_d  = clear || fire;
      pstep_d = fire;
      fnr_d   = !clear;
      zs_d    = pstep_q;
      busy_d  = state_d == CLEAR || state_d == RUN || state_d == PAUSE;
      done_d  = state_d == DONE;
   end
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
         tick_q  <= '0;
         cnt_q   <= '0;
         sh_q    <= '0;
         hits_q  <= '0;
         step_q  <= 1'b0;
         pstep_q <= 1'b0;
         zs_q    <= 1'b0;
         w_q     <= 1'b0;
         fnr_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         hits_q  <= hits_d;
         step_q  <= step_d;
         pstep_q <= pstep_d;
         zs_q    <= zs_d;
         w_q     <= w_d;
         fnr_q   <= fnr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   assign step_o       = step_q;
   assign w_o          = w_q;
   assign fsm_nreset_o = fnr_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign idx_o        = cnt_q[IDX_W-1:0];
   assign hits_o       = hits_q;
endmodule

// File: tb/tb_fsm_stim_sequencer.sv
// tb_fsm_stim_sequencer: directed checks of the stimulus sequencer against a seq4 FSM model
module tb_fsm_stim_sequencer;
   logic clk = 0, nReset = 0, start_i = 0, stop_i = 0, step_i = 0;
   logic [15:0] pattern_i = '0;
   logic [25:0] period_i = 26'd3;
   logic z_i, step_o, w_o, fsm_nreset_o, busy_o, done_o;
   logic [4:0] idx_o;
   logic [7:0] hits_o;
   logic start2 = 0;
   logic [299:0] pat2 = '1;
   logic [25:0] per2 = '0;
   logic step2, w2, fnr2, busy2, done2;
   logic [8:0] idx2;
   logic [7:0] hits2;
   int n_cmp = 0, n_err = 0, nsteps = 0, ns = 0, r = 0;
   logic b = 0;
   always #5 clk = ~clk;
   fsm_stim_sequencer #(.PAT_LEN(16), .IDX_W(5), .DIV_W(26)) dut (
      .Clock(clk), .nReset(nReset), .start_i(start_i), .stop_i(stop_i), .step_i(step_i),
      .pattern_i(pattern_i), .period_i(period_i), .z_i(z_i), .step_o(step_o), .w_o(w_o),
      .fsm_nreset_o(fsm_nreset_o), .busy_o(busy_o), .done_o(done_o), .idx_o(idx_o), .hits_o(hits_o));
   fsm_stim_sequencer #(.PAT_LEN(300), .IDX_W(9), .DIV_W(26)) dut2 (
      .Clock(clk), .nReset(nReset), .start_i(start2), .stop_i(1'b0), .step_i(1'b0),
      .pattern_i(pat2), .period_i(per2), .z_i(1'b1), .step_o(step2), .w_o(w2),
      .fsm_nreset_o(fnr2), .busy_o(busy2), .done_o(done2), .idx_o(idx2), .hits_o(hits2));
   // seq4 model: Moore z=1 once four equal w values have been stepped in a row
   assign z_i = (r == 4);
   always @(posedge clk) begin
      if (step_o) nsteps <= nsteps + 1;
      if (step_o && !fsm_nreset_o) r <= 0;
      else if (step_o && (r == 0 || w_o != b)) begin r <= 1; b <= w_o; end
      else if (step_o && r < 4) r <= r + 1;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask
   task automatic pulse_start;
      start_i = 1;
      cyc;
      start_i = 0;
   endtask
   task automatic wait_idx(input int v, input int lim);
      int i = 0;
      while (idx_o != v && i < lim) begin cyc; i++; end
      chk("wait_idx", idx_o, v);
   endtask
   task automatic wait_done(input int lim);
      int i = 0;
      while (!done_o && i < lim) begin cyc; i++; end
      chk("wait_done", done_o, 1);
   endtask
   initial begin
      #12;
      chk("rst_step", step_o, 0);
      chk("rst_w", w_o, 0);
      chk("rst_fnr", fsm_nreset_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_idx", idx_o, 0);
      chk("rst_hits", hits_o, 0);
      nReset = 1;
      cyc;
      step_i = 1;
      cyc;
      step_i = 0;
      cyc;
      chk("idle_step_ignored", step_o, 0);
      pattern_i = 16'h00F0;
      period_i  = 26'd3;
      pulse_start;
      chk("clr_step", step_o, 1);
      chk("clr_fnr", fsm_nreset_o, 0);
      chk("clr_w", w_o, 0);
      chk("clr_busy", busy_o, 1);
      for (int k = 1; k <= 16; k++) begin
         cyc;
         chk("p3_gap1", step_o, 0);
         cyc;
         chk("p3_gap2", step_o, 0);
         cyc;
         chk("p3_step", step_o, 1);
         chk("p3_w", w_o, pattern_i[k-1]);
         chk("p3_idx", idx_o, k);
         chk("p3_fnr", fsm_nreset_o, 1);
      end
      cyc;
      chk("p3_not_done_yet", done_o, 0);
      cyc;
      chk("p3_done", done_o, 1);
      chk("p3_busy", busy_o, 0);
      chk("p3_hits", hits_o, 7);
      chk("p3_idx_final", idx_o, 16);
      pattern_i = 16'h0F0F;
      period_i  = 26'd2;
      pulse_start;
      chk("rerun_clr", fsm_nreset_o, 0);
      chk("rerun_hits_clr", hits_o, 0);
      wait_done(200);
      chk("f0f_hits", hits_o, 4);
      chk("f0f_idx", idx_o, 16);
      period_i = 26'd4;
      pulse_start;
      wait_idx(5, 100);
      stop_i = 1;
      cyc;
      stop_i = 0;
      ns = nsteps;
      repeat (100) cyc;
      chk("pause_quiet", nsteps, ns);
      chk("pause_busy", busy_o, 1);
      chk("pause_idx", idx_o, 5);
      for (int k = 0; k < 3; k++) begin
         step_i = 1;
         cyc;
         step_i = 0;
         chk("single_step", step_o, 1);
         cyc;
         cyc;
      end
      chk("steps3_idx", idx_o, 8);
      chk("steps3_count", nsteps, ns + 3);
      pulse_start;
      for (int k = 0; k < 3; k++) begin
         cyc;
         chk("resume_gap", step_o, 0);
      end
      cyc;
      chk("resume_step", step_o, 1);
      chk("resume_idx", idx_o, 9);
      wait_done(300);
      chk("pause_hits", hits_o, 4);
      chk("pause_idx_final", idx_o, 16);
      pattern_i = 16'h00F0;
      period_i  = 26'd0;
      pulse_start;
      chk("p0_clr", fsm_nreset_o, 0);
      for (int k = 1; k <= 16; k++) begin
         cyc;
         chk("p0_step", step_o, 1);
         chk("p0_idx", idx_o, k);
      end
      cyc;
      chk("p0_step_end", step_o, 0);
      chk("p0_not_done_yet", done_o, 0);
      cyc;
      chk("p0_done", done_o, 1);
      chk("p0_hits", hits_o, 7);
      period_i = 26'd5;
      pulse_start;
      repeat (7) cyc;
      start_i = 1;
      stop_i  = 1;
      cyc;
      start_i = 0;
      stop_i  = 0;
      chk("sim_pause_busy", busy_o, 1);
      ns = nsteps;
      repeat (20) cyc;
      chk("sim_pause_quiet", nsteps, ns);
      chk("sim_pause_idx", idx_o, 1);
      stop_i = 1;
      step_i = 1;
      cyc;
      stop_i = 0;
      step_i = 0;
      chk("abort_busy", busy_o, 0);
      chk("abort_step", step_o, 0);
      repeat (5) cyc;
      chk("abort_quiet", nsteps, ns);
      chk("abort_idx_held", idx_o, 1);
      pattern_i = 16'h0060;
      period_i  = 26'd3;
      pulse_start;
      wait_idx(7, 100);
      chk("mid_hits", hits_o, 2);
      #2 nReset = 0;
      #1;
      chk("arst_step", step_o, 0);
      chk("arst_w", w_o, 0);
      chk("arst_fnr", fsm_nreset_o, 1);
      chk("arst_busy", busy_o, 0);
      chk("arst_done", done_o, 0);
      chk("arst_idx", idx_o, 0);
      chk("arst_hits", hits_o, 0);
      #2 nReset = 1;
      cyc;
      cyc;
      chk("arst_idle", busy_o, 0);
      pulse_start;
      chk("restart_step", step_o, 1);
      chk("restart_fnr", fsm_nreset_o, 0);
      wait_done(200);
      chk("r060_hits", hits_o, 8);
      start2 = 1;
      cyc;
      start2 = 0;
      begin
         int i = 0;
         while (!done2 && i < 1000) begin cyc; i++; end
      end
      chk("sat_done", done2, 1);
      chk("sat_hits", hits2, 255);
      chk("sat_idx", idx2, 300);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
